// File: rtl/uart_rx_fifo_mm_if.sv
// Bundles the buart receive handshake, the data-bus port B signals and the interrupt line.
// Combinational wiring only: it adds no latency.
// No backpressure of its own; flow control is the rx_valid/rx_rd handshake it carries.
interface uart_rx_fifo_mm_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_rd;
    logic [31:0] addr_b;
    logic [31:0] data_b_in;
    logic [31:0] data_b_we;
    logic [31:0] data_b;
    logic        strobe_b;
    logic        irq;

    // Receiver and CPU side: drives bytes and bus requests, observes responses.
    modport master (
        output rx_valid, rx_data, addr_b, data_b_in, data_b_we,
        input  rx_rd, data_b, strobe_b, irq
    );

    // Buffer side: acknowledges bytes and answers the bus.
    modport slave (
        input  rx_valid, rx_data, addr_b, data_b_in, data_b_we,
        output rx_rd, data_b, strobe_b, irq
    );
endinterface

// File: rtl/uart_rx_fifo_mm.sv
// Memory-mapped receive FIFO that drains buart and exposes STATUS/DATA/CTRL registers.
// Bus reads answer one cycle after the address; a byte is in the FIFO two cycles after rx_valid.
// A push into a full FIFO without a simultaneous pop is dropped and sets sticky ovf; the ack still completes.
module uart_rx_fifo_mm #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] ADDR_BASE = 32'd65541
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_fifo_mm_if.slave  bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    count;
    logic          ovf;
    logic          irq_en;
    logic [7:0]    thresh;

    logic [31:0]   off;
    logic          hit;
    logic          wr;
    logic          full;
    logic          nempty;
    logic          pop;
    logic          push_try;
    logic          push_ok;
    logic [7:0]    head;
    logic [31:0]   rdata;

    // Offset from the register base; addresses below the base wrap to large values and miss.
    assign off      = bus.addr_b - ADDR_BASE;
    assign hit      = (off < 32'd3);
    assign wr       = |bus.data_b_we;
    assign full     = (count == DEPTH_C);
    assign nempty   = (count != 8'd0);
    assign head     = mem[rd_ptr];
    assign pop      = hit && !wr && (off[1:0] == 2'd1) && nempty;
    assign push_try = (state == ACK);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_try && (!full || pop);

    // Capture FSM: one-cycle rd pulse per byte, never re-acknowledging while rx_rd is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus.rx_rd <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_valid && !bus.rx_rd) begin
                        bus.rx_rd <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    bus.rx_rd <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.rx_rd <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 8'd0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + {7'd0, push_ok} - {7'd0, pop};
            if (push_try && full && !pop)
                ovf <= 1'b1;
            else if (hit && wr && (off[1:0] == 2'd0) && bus.data_b_in[2])
                ovf <= 1'b0;
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.rx_data;
    end

    // CTRL register writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            thresh <= 8'd1;
        end else if (hit && wr && (off[1:0] == 2'd2)) begin
            irq_en <= bus.data_b_in[0];
            thresh <= bus.data_b_in[15:8];
        end
    end

    // Read-data mux; writes and misses return zero.
    always_comb begin
        rdata = 32'd0;
        if (hit && !wr) begin
            case (off[1:0])
                2'd0:    rdata = {16'd0, count, 5'd0, ovf, full, nempty};
                2'd1:    rdata = {24'd0, nempty ? head : 8'd0};
                2'd2:    rdata = {16'd0, thresh, 7'd0, irq_en};
                default: rdata = 32'd0;
            endcase
        end
    end

    // Registered bus response, one cycle after the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_b   <= 32'd0;
            bus.strobe_b <= 1'b0;
        end else begin
            bus.data_b   <= rdata;
            bus.strobe_b <= hit;
        end
    end

    // Level interrupt from the registered occupancy, so it trails count by one cycle.
    always_ff @(posedge clk) begin
        if (rst) bus.irq <= 1'b0;
        else     bus.irq <= irq_en && (count >= thresh);
    end
endmodule

// File: tb/tb_uart_rx_fifo_mm.sv
module tb_uart_rx_fifo_mm;
    localparam logic [31:0] BASE = 32'd65541;
    localparam logic [31:0] ST   = BASE;
    localparam logic [31:0] DT   = BASE + 32'd1;
    localparam logic [31:0] CT   = BASE + 32'd2;
    localparam int          DEP  = 16;

    logic clk;
    logic rst;
    uart_rx_fifo_mm_if bif();

    uart_rx_fifo_mm #(.DEPTH(DEP), .ADDR_BASE(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int long_pulses = 0;
    int exp_pulses = 0;
    logic rd_prev = 1'b0;

    // Reference model: plain byte queue plus sticky overflow flag.
    logic [7:0] q[$];
    logic       m_ovf;

    always @(negedge clk) begin
        if (bif.rx_rd && !rd_prev) pulses++;
        if (bif.rx_rd && rd_prev)  long_pulses++;
        rd_prev = bif.rx_rd;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = q.size();
        return {16'd0, 8'(n), 5'd0, m_ovf, (n == DEP), (n != 0)};
    endfunction

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic bus_acc(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           output logic [31:0] rd, output logic st);
        bif.addr_b    = a;
        bif.data_b_we = w ? 32'h0000_0100 : 32'd0;
        bif.data_b_in = wd;
        @(posedge clk); #1;
        rd = bif.data_b;
        st = bif.strobe_b;
        bif.addr_b    = 32'd0;
        bif.data_b_we = 32'd0;
        bif.data_b_in = 32'd0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic s;
        bus_acc(a, 1'b0, 32'd0, d, s);
        chk(nm, d, exp);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] d;
        logic s;
        bus_acc(a, 1'b1, wd, d, s);
    endtask

    task automatic pop_chk(input string nm);
        logic [7:0] e;
        e = (q.size() != 0) ? q.pop_front() : 8'd0;
        rd_chk(nm, DT, {24'd0, e});
    endtask

    task automatic send_byte(input logic [7:0] b, output int lat);
        logic ok = 1'b0;
        lat = 0;
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bif.rx_rd) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
        end
        chk("rx_ack_seen", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        bif.rx_valid = 1'b0;
        chk("rx_rd_one_cycle", {31'd0, bif.rx_rd}, 32'd0);
        exp_pulses++;
        if (q.size() < DEP) q.push_back(b);
        else                m_ovf = 1'b1;
    endtask

    // Acknowledge a byte while a DATA read hits in the same (ACK) cycle.
    task automatic push_pop(input logic [7:0] b, input string nm);
        logic [7:0] e;
        bif.rx_valid = 1'b1;
        bif.rx_data  = b;
        @(posedge clk); #1;
        chk({nm, "_ack"}, {31'd0, bif.rx_rd}, 32'd1);
        bif.addr_b = DT;
        @(posedge clk); #1;
        bif.addr_b   = 32'd0;
        bif.rx_valid = 1'b0;
        e = (q.size() != 0) ? q.pop_front() : 8'd0;
        chk({nm, "_data"}, bif.data_b, {24'd0, e});
        if (q.size() < DEP) q.push_back(b);
        else                m_ovf = 1'b1;
        exp_pulses++;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        chk_dat;
        logic [31:0] exp_dat;
        logic        exp_stb;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [31:0] d;
        logic        s;
        int          lat;
        logic [7:0]  b;

        vt[0]  = '{ST,          1'b0, 32'd0,         1'b1, 32'h0,   1'b1};
        vt[1]  = '{CT,          1'b0, 32'd0,         1'b1, 32'h100, 1'b1};
        vt[2]  = '{DT,          1'b0, 32'd0,         1'b1, 32'h0,   1'b1};
        vt[3]  = '{BASE + 32'd3, 1'b0, 32'd0,        1'b1, 32'h0,   1'b0};
        vt[4]  = '{BASE - 32'd1, 1'b0, 32'd0,        1'b1, 32'h0,   1'b0};
        vt[5]  = '{CT,          1'b1, 32'h0000_0A01, 1'b0, 32'h0,   1'b1};
        vt[6]  = '{CT,          1'b0, 32'd0,         1'b1, 32'hA01, 1'b1};
        vt[7]  = '{ST,          1'b1, 32'hFFFF_FFFB, 1'b0, 32'h0,   1'b1};
        vt[8]  = '{ST,          1'b0, 32'd0,         1'b1, 32'h0,   1'b1};
        vt[9]  = '{DT,          1'b1, 32'h55,        1'b0, 32'h0,   1'b1};
        vt[10] = '{ST,          1'b0, 32'd0,         1'b1, 32'h0,   1'b1};
        vt[11] = '{CT,          1'b1, 32'h0000_0100, 1'b0, 32'h0,   1'b1};
        vt[12] = '{BASE + 32'd3, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,  1'b0};
        vt[13] = '{CT,          1'b0, 32'd0,         1'b1, 32'h100, 1'b1};
        vt[14] = '{BASE + 32'd4, 1'b0, 32'd0,        1'b1, 32'h0,   1'b0};

        rst = 1'b1;
        bif.rx_valid  = 1'b0;
        bif.rx_data   = 8'd0;
        bif.addr_b    = 32'd0;
        bif.data_b_in = 32'd0;
        bif.data_b_we = 32'd0;
        q.delete();
        m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_b", bif.data_b, 32'd0);
        chk("reset_strobe_b", {31'd0, bif.strobe_b}, 32'd0);
        rst = 1'b0;

        // Register map after reset, range decoding and ignored writes.
        for (int i = 0; i < 15; i++) begin
            bus_acc(vt[i].addr, vt[i].we, vt[i].wdata, d, s);
            if (vt[i].chk_dat) chk($sformatf("vec%0d_data", i), d, vt[i].exp_dat);
            chk($sformatf("vec%0d_strobe", i), {31'd0, s}, {31'd0, vt[i].exp_stb});
            chk($sformatf("vec%0d_irq", i), {31'd0, bif.irq}, 32'd0);
            chk($sformatf("vec%0d_rx_rd", i), {31'd0, bif.rx_rd}, 32'd0);
        end

        // Three bytes in order, with the first-byte latency and count evolution.
        send_byte(8'h41, lat);
        chk("ack_latency", lat, 32'd1);
        rd_chk("status_after_1", ST, 32'h101);
        send_byte(8'h42, lat);
        send_byte(8'h43, lat);
        chk("three_pulses", pulses, exp_pulses);
        rd_chk("status_3", ST, 32'h301);
        pop_chk("data_41");
        rd_chk("status_2", ST, 32'h201);
        pop_chk("data_42");
        rd_chk("status_1", ST, 32'h101);
        pop_chk("data_43");
        rd_chk("status_0", ST, 32'h000);

        // Fill, overflow with 0xEE, drain, clear ovf.
        for (int i = 0; i < DEP; i++) send_byte(8'($urandom), lat);
        send_byte(8'hEE, lat);
        chk("overflow_pulses", pulses, exp_pulses);
        rd_chk("status_full_ovf", ST, 32'h1007);
        for (int i = 0; i < DEP; i++) pop_chk($sformatf("drain_ovf_%0d", i));
        rd_chk("status_drained_ovf", ST, 32'h0004);
        wr_reg(ST, 32'h4);
        m_ovf = 1'b0;
        rd_chk("status_ovf_cleared", ST, 32'h0);

        // Full FIFO: push and pop in the same cycle.
        for (int i = 0; i < DEP; i++) send_byte(8'(8'h10 + i), lat);
        push_pop(8'h5A, "full_pushpop");
        rd_chk("status_full_pushpop", ST, 32'h1003);
        for (int i = 0; i < DEP - 1; i++) pop_chk($sformatf("drain_pp_%0d", i));
        rd_chk("last_is_new", DT, 32'h5A);
        void'(q.pop_front());
        rd_chk("status_pp_empty", ST, exp_status());

        // Threshold interrupt.
        wr_reg(CT, 32'h0401);
        for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i), lat);
        @(posedge clk); #1;
        chk("irq_below_thresh", {31'd0, bif.irq}, 32'd0);
        send_byte(8'hA3, lat);
        chk("irq_same_cycle_as_count4", {31'd0, bif.irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_rise", {31'd0, bif.irq}, 32'd1);
        pop_chk("irq_pop");
        chk("irq_hold_count3", {31'd0, bif.irq}, 32'd1);
        @(posedge clk); #1;
        chk("irq_fall", {31'd0, bif.irq}, 32'd0);
        for (int i = 0; i < 3; i++) pop_chk($sformatf("irq_drain_%0d", i));
        wr_reg(CT, 32'h0001);
        @(posedge clk); #1;
        chk("irq_thresh0", {31'd0, bif.irq}, 32'd1);
        wr_reg(CT, 32'h0100);
        @(posedge clk); #1;
        chk("irq_disabled", {31'd0, bif.irq}, 32'd0);

        // Reset while in ACK with rx_valid held.
        bif.rx_valid = 1'b1;
        bif.rx_data  = 8'h77;
        @(posedge clk); #1;
        chk("pre_reset_ack", {31'd0, bif.rx_rd}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_clears_rx_rd", {31'd0, bif.rx_rd}, 32'd0);
        q.delete();
        m_ovf = 1'b0;
        exp_pulses++;
        send_byte(8'h77, lat);
        pop_chk("reack_data");
        rd_chk("reack_status_empty", ST, 32'h0);
        rd_chk("reack_ctrl_reset", CT, 32'h100);
        send_byte(8'h78, lat);
        rd_chk("reack_count1", ST, 32'h101);
        pop_chk("reack_data2");

        // Randomized operations against the queue model.
        for (int n = 0; n < 400; n++) begin
            int op = $urandom_range(0, 9);
            if (op <= 4) begin
                send_byte(8'($urandom), lat);
            end else if (op <= 6) begin
                pop_chk($sformatf("rnd_pop_%0d", n));
            end else if (op == 7) begin
                rd_chk($sformatf("rnd_status_%0d", n), ST, exp_status());
            end else if (op == 8) begin
                b = 8'($urandom);
                push_pop(b, $sformatf("rnd_pp_%0d", n));
            end else begin
                wr_reg(ST, 32'h4);
                m_ovf = 1'b0;
            end
        end
        rd_chk("rnd_final_status", ST, exp_status());
        while (q.size() != 0) pop_chk("rnd_drain");
        rd_chk("rnd_empty_status", ST, exp_status());
        rd_chk("rnd_empty_data", DT, 32'h0);

        chk("total_rx_rd_pulses", pulses, exp_pulses);
        chk("no_long_rx_rd", long_pulses, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
